// File: rtl/lagline_serializer_if.sv
// lagline_serializer_if: line-load, video-timing and pixel-output signals of the lag-display serializer
interface lagline_serializer_if #(parameter int LINE_BITS = 160);
  logic                 load;
  logic [LINE_BITS-1:0] line_in;
  logic [11:0]          counterX;
  logic                 line_active;
  logic [11:0]          h_start;
  logic [1:0]           h_scale;
  logic                 pixel_on;
  logic                 busy;
  modport master (output load, line_in, counterX, line_active, h_start, h_scale, input pixel_on, busy);
  modport slave  (input load, line_in, counterX, line_active, h_start, h_scale, output pixel_on, busy);
endinterface

// File: rtl/lagline_serializer.sv
// lagline_serializer: shifts a captured glyph line out as a 1-bit pixel stream with replication; shadow buffer enabled by LAGLINE_DBUF_EN
module lagline_serializer #(
  parameter int LINE_BITS = 160
) (
  input logic              clock,
  input logic              reset,
  lagline_serializer_if.slave bus
);
  localparam int BW = $clog2(LINE_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t               r_state, w_state_nx;
  logic [LINE_BITS-1:0] r_shift, w_shift_nx, w_src;
  logic [BW-1:0]        r_bit, w_bit_nx;
  logic [2:0]           r_rep, w_rep_nx, w_rep_max;
  logic [1:0]           r_scale, w_scale_nx;
  logic                 r_pixel, w_pixel_nx, r_busy, w_busy_nx;
  logic                 w_start, w_abort, w_wrap, w_last, w_run;
`ifdef LAGLINE_DBUF_EN
  logic [LINE_BITS-1:0] r_shadow;
  // shadow buffer takes a new line whenever load strobes, independent of any run in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) r_shadow <= '0;
    else if (bus.load) r_shadow <= bus.line_in;
  assign w_src = r_shadow;
`else
  logic w_unused_load;
  assign w_unused_load = bus.load;
  assign w_src = bus.line_in;
`endif
  assign w_start   = r_state == IDLE && bus.line_active && bus.counterX == bus.h_start;
  assign w_abort   = bus.counterX == 12'd0 || !bus.line_active;
  assign w_rep_max = ~(3'b111 << r_scale);
  assign w_wrap    = r_rep == w_rep_max;
  assign w_last    = w_wrap && r_bit == BW'(LINE_BITS - 1);
  assign w_run     = r_state == SHIFT && !w_abort && !w_last;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  // next state: abort wins over completion in SHIFT; DONE waits for the line wrap
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == IDLE)  ? (w_start ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_abort ? IDLE : (w_last ? DONE : SHIFT)) :
                 (bus.counterX == 12'd0 ? IDLE : DONE);
  end
  // datapath and output next values; the pixel presented next is the MSB after this cycle's shift
  always_comb begin
    w_rep_nx   = w_start ? 3'd0 : (r_state == SHIFT) ? (w_wrap ? 3'd0 : r_rep + 3'd1) : r_rep;
    w_bit_nx   = w_start ? '0 : (r_state == SHIFT && w_wrap) ? r_bit + BW'(1) : r_bit;
    w_shift_nx = w_start ? w_src : (r_state == SHIFT && w_wrap) ? r_shift << 1 : r_shift;
    w_scale_nx = w_start ? bus.h_scale : r_scale;
    w_pixel_nx = w_start ? w_src[LINE_BITS-1] : (w_run ? w_shift_nx[LINE_BITS-1] : 1'b0);
    w_busy_nx  = w_start || w_run;
  end
  // datapath and registered outputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_scale <= '0;
      r_pixel <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_shift <= w_shift_nx;
      r_bit   <= w_bit_nx;
      r_rep   <= w_rep_nx;
      r_scale <= w_scale_nx;
      r_pixel <= w_pixel_nx;
      r_busy  <= w_busy_nx;
    end
  assign bus.pixel_on = r_pixel;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_lagline_serializer.sv
// tb_lagline_serializer: directed and random scanlines checked against a pixel-index reference model
module tb_lagline_serializer;
  localparam int L = 160;
  logic clock = 1'b0, reset = 1'b1;
  lagline_serializer_if #(.LINE_BITS(L)) bus ();
  lagline_serializer #(.LINE_BITS(L)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  int total = 0, passes = 0;
  int cnt_pix, cnt_busy;
  int g_hs, g_sc, g_ldx, g_ldx2, g_drop, g_chg;
  logic g_la;
  logic [L-1:0] g_ldd, g_ldd2;
  logic [L-1:0] m_shadow, m_data;
  int m_n, m_s, m_mode;
  logic exp_pix, exp_busy;
  task automatic chk(input string tag, input int act, input int exp);
    total++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask
  task automatic model_reset();
    m_shadow = '0; m_data = '0; m_n = 0; m_s = 0; m_mode = 0; exp_pix = 0; exp_busy = 0;
  endtask
  task automatic model_step();
    logic [L-1:0] src;
`ifdef LAGLINE_DBUF_EN
    src = m_shadow;
`else
    src = bus.line_in;
`endif
    exp_pix = 0; exp_busy = 0;
    if (m_mode == 1) begin
      if (bus.counterX == 0 || !bus.line_active) m_mode = 0;
      else begin
        m_n++;
        if (m_n == (L << m_s)) m_mode = 2;
        else begin exp_pix = m_data[L-1-(m_n >> m_s)]; exp_busy = 1; end
      end
    end else if (m_mode == 2) begin
      if (bus.counterX == 0) m_mode = 0;
    end else if (bus.line_active && bus.counterX == bus.h_start) begin
      m_data = src; m_s = int'(bus.h_scale); m_n = 0; m_mode = 1;
      exp_pix = m_data[L-1]; exp_busy = 1;
    end
`ifdef LAGLINE_DBUF_EN
    if (bus.load) m_shadow = bus.line_in;
`endif
  endtask
  task automatic tick();
    model_step();
    @(posedge clock); #1;
    chk("pixel_on", int'(bus.pixel_on), int'(exp_pix));
    chk("busy", int'(bus.busy), int'(exp_busy));
    cnt_pix += int'(bus.pixel_on);
    cnt_busy += int'(bus.busy);
  endtask
  task automatic setl(input int hs, input int sc, input int ldx, input logic [L-1:0] ldd);
    g_hs = hs; g_sc = sc; g_ldx = ldx; g_ldd = ldd;
    g_ldx2 = -1; g_drop = -1; g_chg = -1; g_la = 1'b1;
  endtask
  task automatic line(input int htotal, input int stop);
    cnt_pix = 0; cnt_busy = 0;
    bus.h_start = 12'(g_hs); bus.h_scale = 2'(g_sc);
    for (int x = 0; x < stop && x < htotal; x++) begin
      bus.counterX = 12'(x);
      bus.line_active = g_la && !(g_drop >= 0 && x >= g_drop);
      bus.load = 1'b0;
      if (x == g_ldx) begin bus.line_in = g_ldd; bus.load = 1'b1; end
      if (x == g_ldx2) begin bus.line_in = g_ldd2; bus.load = 1'b1; end
      if (x == g_chg) begin bus.h_start = 12'($urandom_range(0, 300)); bus.h_scale = 2'($urandom); end
      tick();
    end
    bus.load = 1'b0;
  endtask
  function automatic logic [L-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [L-1:0] alt, a_d, b_d, c_d;
    int hs, sc, ht;
    bus.load = 0; bus.line_in = '0; bus.counterX = '0; bus.line_active = 0; bus.h_start = '0; bus.h_scale = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_pixel_on", int'(bus.pixel_on), 0);
    chk("reset_busy", int'(bus.busy), 0);
    reset = 1'b0;
    setl(100, 0, 10, {1'b1, {(L-1){1'b0}}});
    line(400, 400);
    chk("single_busy_len", cnt_busy, L);
    chk("single_pix_count", cnt_pix, 1);
    for (int i = 0; i < L; i++) alt[i] = i[0];
    setl(50, 2, 3, alt);
    line(800, 800);
    chk("rep_busy_len", cnt_busy, L << 2);
    chk("rep_pix_count", cnt_pix, (L / 2) << 2);
    a_d = rnd_line(); b_d = rnd_line(); c_d = rnd_line();
    setl(20, 0, 5, a_d);
    g_ldx2 = 60; g_ldd2 = b_d;
    line(300, 300);
    chk("dbuf_busy_len", cnt_busy, L);
    setl(20, 0, -1, '0);
    line(300, 300);
    setl(20, 1, 20, c_d);
    line(500, 500);
    chk("dbuf_sim_busy_len", cnt_busy, L << 1);
    setl(20, 0, -1, '0);
    line(300, 300);
    setl(40, 0, 2, rnd_line());
    g_drop = 90;
    line(300, 300);
    chk("abort_drop_busy", cnt_busy, 50);
    setl(40, 0, -1, '0);
    line(110, 110);
    chk("abort_wrap_busy", cnt_busy, 70);
    line(300, 300);
    chk("after_wrap_busy", cnt_busy, L);
    setl(0, 0, 5, rnd_line());
    line(300, 300);
    chk("hstart0_deferred", cnt_busy, 0);
    line(300, 300);
    chk("hstart0_next_line", cnt_busy, L);
    setl(30, 1, 2, rnd_line());
    line(400, 70);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pixel_on", int'(bus.pixel_on), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    setl(30, 0, -1, '0);
    line(300, 300);
`ifdef LAGLINE_DBUF_EN
    chk("post_rst_no_load_pix", cnt_pix, 0);
`endif
    for (int k = 0; k < 14; k++) begin
      hs = (k == 3) ? 0 : int'($urandom_range(1, 200));
      sc = int'($urandom_range(0, 3));
      ht = hs + (L << sc) + int'($urandom_range(1, 30));
      if ($urandom_range(0, 3) == 0) ht = hs + int'($urandom_range(1, L << sc));
      setl(hs, sc, int'($urandom_range(0, ht)), rnd_line());
      if ($urandom_range(0, 1) == 1) begin g_ldx2 = int'($urandom_range(0, ht)); g_ldd2 = rnd_line(); end
      if ($urandom_range(0, 3) == 0) g_drop = hs + int'($urandom_range(0, L << sc));
      g_chg = hs + 5;
      line(ht, ht);
    end
    setl(100, 0, -1, '0);
`ifdef LAGLINE_DBUF_EN
    g_ldx = 1; g_ldd = '1;
`else
    bus.line_in = '1;
`endif
    line(400, 400);
    line(400, 400);
    chk("all_ones_pix_count", cnt_pix, L);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/lagline_serializer.md
# lagline_serializer

Reader side of the lag-display line path: captures the per-scanline glyph bitmap assembled by the text generator and shifts it out as a 1-bit pixel stream during active video. Sits between the text generator and the video mixer; the mixer ORs `pixel_on` into the output colour. It supports horizontal pixel replication and double buffering, so a new line can be loaded while the current one is still being drawn.

## Interface
- `LINE_BITS`, 160: width of the bitmap line; bit `LINE_BITS-1` is the leftmost pixel.
- `clock`  in  1  video pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `line_in` into the shadow register.
- `line_in`  in  LINE_BITS  glyph bitmap from the text generator.
- `counterX`  in  12  horizontal pixel counter from video timing; 0 starts a line.
- `line_active`  in  1  high while the current scanline lies inside the lag-display window.
- `h_start`  in  12  `counterX` value of the first displayed pixel.
- `h_scale`  in  2  log2 of the horizontal replication: 0 = 1x, 1 = 2x, 2 = 4x, 3 = 8x.
- `pixel_on`  out  1  registered pixel output.
- `busy`  out  1  high while a line is being shifted out.

## Operation
- States:
  - IDLE: waits for a start.
  - SHIFT: shifts the line out.
  - DONE: holds until the next line.
- Start condition: `line_active && counterX == h_start` in IDLE.
  - Copies the shadow register into the shift register.
  - Latches `h_scale`.
  - Clears the replication counter and the bit counter, then enters SHIFT.
- SHIFT:
  - Each cycle the replication counter increments.
  - When it reaches `(1<<scale)-1`, it wraps to 0, the shift register moves one bit toward the MSB, and the bit counter increments.
  - When the bit counter reaches `LINE_BITS` at a wrap, the block enters DONE.
- DONE → IDLE when `counterX == 0`.
- Aborts:
  - In SHIFT, `counterX == 0` or `line_active == 0` forces IDLE.
  - The next `pixel_on` is 0.
- Shadow register updates on `load` in any state; an in-flight run is unaffected.
- `load` and start in the same cycle: the run uses the old shadow contents, and the shadow takes the new `line_in`.
- Changes to `h_start` or `h_scale` during SHIFT are ignored until the next start.
- Bit counter width is `$clog2(LINE_BITS+1)`; replication counter width is 3 bits.

## Timing
- Reset values:
  - `pixel_on` = 0, `busy` = 0.
  - State = IDLE.
  - Shadow register, shift register and counters = 0.
- Latency is 1 cycle. For n in 0 .. `(LINE_BITS<<scale)-1`, `pixel_on` in the cycle after `counterX == h_start + n` equals shadow bit `LINE_BITS-1-(n>>scale)`. Otherwise `pixel_on` = 0.
- `busy` is registered and high for exactly `LINE_BITS<<scale` cycles, aligned with the valid `pixel_on` window.
- A `load` at cycle t is visible to a start at cycle t+1 or later.
- Reset asserted mid-run clears all outputs immediately (asynchronous). The first run after release needs a fresh `load`.
- `h_start == 0`: the start and the DONE→IDLE condition coincide. Start takes priority from IDLE; DONE→IDLE happens first, so the run starts on the next line.

## Configuration
- `LAGLINE_DBUF_EN` defined:
  - Shadow register is present and behaves as described above.
- `LAGLINE_DBUF_EN` undefined:
  - No shadow register; `load` is ignored.
  - At start, `line_in` is sampled directly into the shift register.
  - The upstream must hold `line_in` stable from one cycle before `h_start` onward.

## Test plan
- Single run: `LINE_BITS` = 160, `line_in` = {1'b1, 159'b0}, `load`, `h_start` = 100, `h_scale` = 0 → `pixel_on` is 1 only in the cycle after `counterX` = 100; `busy` is high for 160 cycles.
- Replication: `line_in` = alternating 1010…, `h_scale` = 2 → `pixel_on` toggles every 4 cycles for 640 cycles starting one cycle after `h_start`.
- Double buffer: load A, start, load B during SHIFT → the full line shows A. The next line shows B. A simultaneous `load` and start also shows the old data.
- Abort: `line_active` drops at `counterX` = `h_start` + 50 → `pixel_on` = 0 and `busy` = 0 from the next cycle. A `counterX` wrap mid-run gives the same result.
- Reset mid-SHIFT: assert `reset` asynchronously → `pixel_on` = 0 and `busy` = 0 with no clock edge. After release, no output until a new `load` and start.
- Without `LAGLINE_DBUF_EN`: `load` is never pulsed and `line_in` = all ones → `pixel_on` is high for 160 cycles after `h_start`.
